// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared types and constants for the RV32I pipeline control.
//               Holds the hazard-controller state encoding and the indices
//               of the inter-stage registers (0 = IF/ID).
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    // Hazard controller state encoding
    typedef logic [2:0] hz_state_t;

    localparam hz_state_t c_ST_RUN        = 3'd0;
    localparam hz_state_t c_ST_DSTALL     = 3'd1;
    localparam hz_state_t c_ST_ISTALL     = 3'd2;
    localparam hz_state_t c_ST_LU_BUBBLE  = 3'd3;
    localparam hz_state_t c_ST_REDIR_WAIT = 3'd4;

    // Inter-stage register indices
    localparam int c_IF_ID  = 0;
    localparam int c_ID_EX  = 1;
    localparam int c_EX_MEM = 2;
    localparam int c_MEM_WB = 3;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Flags a load-use hazard: a load in EX writes a register that
//               the instruction in ID actually reads. x0 never hazards.
// Ports       : i_ex_is_load, i_ex_rd        - load in EX and its destination
//               i_id_rs1/2, i_id_use_rs1/2   - ID sources and their use flags
//               o_load_use                   - hazard present this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect (
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rd,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_load_use = i_ex_is_load && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush controller for an in-order pipeline. Produces PC
//               enable/select, per-register load and flush strobes, and
//               saturating stall/flush performance counters.
// Ports       : clk, rst (sync, active-low)
//               imem_resp, dmem_read/write/resp       - memory handshakes
//               ex_is_load, ex_rd, id_rs*, id_use_rs* - load-use inputs
//               redirect, redirect_target              - EX control transfer
//               load_pc, pc_sel_redirect, pc_redirect  - PC control
//               inst_read, stage_load, stage_flush     - pipeline control
//               stall_cycles, flush_count              - perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import rv32i_types::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int LU_BUBBLES  = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_resp,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic                  dmem_resp,
    input  logic                  ex_is_load,
    input  logic [4:0]            ex_rd,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_target,
    output logic                  load_pc,
    output logic                  pc_sel_redirect,
    output logic [XLEN-1:0]       pc_redirect,
    output logic                  inst_read,
    output logic [NUM_STAGES-2:0] stage_load,
    output logic [NUM_STAGES-2:0] stage_flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int c_NR = NUM_STAGES - 1;

    hz_state_t         r_state,      w_state_nxt;
    hz_state_t         r_ret_state,  w_ret_nxt;
    logic [1:0]        r_bub_cnt,    w_bub_nxt;
    logic [XLEN-1:0]   r_target,     w_target_nxt;
    logic [CNT_W-1:0]  r_stall_cnt,  w_stall_nxt;
    logic [CNT_W-1:0]  r_flush_cnt,  w_flush_nxt;

    hz_state_t         w_eff_state;
    logic              w_dstall;
    logic              w_load_use;
    logic              w_accept;
    logic [c_NR-1:0]   w_flush_mask;

    // Registers squashed by a redirect: indices 0..FLUSH_DEPTH-1
    generate
        for (genvar gi = 0; gi < c_NR; gi++) begin : g_flush_mask
            assign w_flush_mask[gi] = (gi < FLUSH_DEPTH);
        end
    endgenerate

    load_use_detect u_load_use_detect (
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_id_use_rs1 (id_use_rs1),
        .i_id_use_rs2 (id_use_rs2),
        .o_load_use   (w_load_use)
    );

    assign w_dstall  = (dmem_read || dmem_write) && !dmem_resp;
    assign inst_read = rst;

    always_comb begin
        // While parked in DSTALL, behave as the state held on entry so the
        // response cycle already advances the pipeline.
        w_eff_state     = (r_state == c_ST_DSTALL) ? r_ret_state : r_state;
        w_state_nxt     = r_state;
        w_ret_nxt       = r_ret_state;
        w_bub_nxt       = r_bub_cnt;
        w_target_nxt    = r_target;
        w_accept        = 1'b0;
        load_pc         = 1'b1;
        pc_sel_redirect = 1'b0;
        pc_redirect     = (w_eff_state == c_ST_REDIR_WAIT) ? r_target : redirect_target;
        stage_load      = '1;
        stage_flush     = '0;

        if (w_dstall) begin
            load_pc     = 1'b0;
            stage_load  = '0;
            w_state_nxt = c_ST_DSTALL;
            if (r_state != c_ST_DSTALL) begin
                w_ret_nxt = r_state;
            end
        end else begin
            w_state_nxt = c_ST_RUN;
            case (w_eff_state)
                c_ST_REDIR_WAIT: begin
                    if (!imem_resp) begin
                        load_pc     = 1'b0;
                        stage_flush = w_flush_mask;
                        w_state_nxt = c_ST_REDIR_WAIT;
                    end else begin
                        // Returned instruction belongs to the old path
                        pc_sel_redirect      = 1'b1;
                        stage_flush[c_IF_ID] = 1'b1;
                    end
                end
                default: begin
                    if (!imem_resp) begin
                        // Fetch miss: bubble into IF/ID, older stages drain
                        load_pc              = 1'b0;
                        stage_flush[c_IF_ID] = 1'b1;
                        w_bub_nxt            = 2'd0;
                        w_state_nxt          = c_ST_ISTALL;
                        if (redirect) begin
                            stage_flush  = w_flush_mask;
                            w_target_nxt = redirect_target;
                            w_accept     = 1'b1;
                            w_state_nxt  = c_ST_REDIR_WAIT;
                        end
                    end else if (redirect) begin
                        // Outranks load-use: the dependent instruction is squashed
                        pc_sel_redirect = 1'b1;
                        stage_flush     = w_flush_mask;
                        w_accept        = 1'b1;
                        w_bub_nxt       = 2'd0;
                    end else if (w_eff_state == c_ST_LU_BUBBLE) begin
                        load_pc              = 1'b0;
                        stage_load[c_IF_ID]  = 1'b0;
                        stage_flush[c_ID_EX] = 1'b1;
                        w_bub_nxt            = r_bub_cnt - 2'd1;
                        w_state_nxt          = (r_bub_cnt <= 2'd1) ? c_ST_RUN : c_ST_LU_BUBBLE;
                    end else if (w_load_use) begin
                        // Detection cycle is the first bubble
                        load_pc              = 1'b0;
                        stage_load[c_IF_ID]  = 1'b0;
                        stage_flush[c_ID_EX] = 1'b1;
                        w_bub_nxt            = 2'(LU_BUBBLES - 1);
                        w_state_nxt          = (LU_BUBBLES > 1) ? c_ST_LU_BUBBLE : c_ST_RUN;
                    end
                end
            endcase
        end

        if (!rst) begin
            load_pc         = 1'b0;
            pc_sel_redirect = 1'b0;
            pc_redirect     = redirect_target;
            stage_load      = '1;
            stage_flush     = '1;
        end

        w_stall_nxt = r_stall_cnt;
        w_flush_nxt = r_flush_cnt;
        if (!load_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
            w_stall_nxt = r_stall_cnt + 1'b1;
        end
        if (w_accept && (r_flush_cnt != {CNT_W{1'b1}})) begin
            w_flush_nxt = r_flush_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_ST_RUN;
            r_ret_state <= c_ST_RUN;
            r_bub_cnt   <= 2'd0;
            r_target    <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_bub_cnt   <= w_bub_nxt;
            r_target    <= w_target_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_flush_cnt <= w_flush_nxt;
        end
    end

    assign stall_cycles = r_stall_cnt;
    assign flush_count  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench. u_dut uses defaults; u_dut2 uses
//               LU_BUBBLES=2 and a 3-bit counter width to exercise the
//               two-bubble load-use and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_resp, dmem_read, dmem_write, dmem_resp;
    logic        ex_is_load;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic        redirect;
    logic [31:0] redirect_target;

    logic        load_pc, pc_sel_redirect, inst_read;
    logic [31:0] pc_redirect;
    logic [3:0]  stage_load, stage_flush;
    logic [31:0] stall_cycles, flush_count;

    logic        load_pc2, pc_sel_redirect2, inst_read2;
    logic [31:0] pc_redirect2;
    logic [3:0]  stage_load2, stage_flush2;
    logic [2:0]  stall_cycles2, flush_count2;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_resp(dmem_resp), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .redirect(redirect), .redirect_target(redirect_target),
        .load_pc(load_pc), .pc_sel_redirect(pc_sel_redirect), .pc_redirect(pc_redirect),
        .inst_read(inst_read), .stage_load(stage_load), .stage_flush(stage_flush),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_resp(dmem_resp), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .redirect(redirect), .redirect_target(redirect_target),
        .load_pc(load_pc2), .pc_sel_redirect(pc_sel_redirect2), .pc_redirect(pc_redirect2),
        .inst_read(inst_read2), .stage_load(stage_load2), .stage_flush(stage_flush2),
        .stall_cycles(stall_cycles2), .flush_count(flush_count2)
    );

    typedef struct {
        string       tag;
        logic        lpc;
        logic        sel;
        logic [31:0] pcr;
        logic        ird;
        logic [3:0]  ld;
        logic [3:0]  fl;
        logic [31:0] st;
        logic [31:0] fc;
        logic        lpc2;
        logic [3:0]  ld2;
        logic [3:0]  fl2;
        logic [2:0]  st2;
        logic [2:0]  fc2;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_st = 0, m_fc = 0, m_st2 = 0, m_fc2 = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: compares at the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            check_val({m_e.tag, ".load_pc"},     64'(load_pc),          64'(m_e.lpc));
            check_val({m_e.tag, ".pc_sel"},      64'(pc_sel_redirect),  64'(m_e.sel));
            check_val({m_e.tag, ".pc_redirect"}, 64'(pc_redirect),      64'(m_e.pcr));
            check_val({m_e.tag, ".inst_read"},   64'(inst_read),        64'(m_e.ird));
            check_val({m_e.tag, ".stage_load"},  64'(stage_load),       64'(m_e.ld));
            check_val({m_e.tag, ".stage_flush"}, 64'(stage_flush),      64'(m_e.fl));
            check_val({m_e.tag, ".stall_cyc"},   64'(stall_cycles),     64'(m_e.st));
            check_val({m_e.tag, ".flush_cnt"},   64'(flush_count),      64'(m_e.fc));
            check_val({m_e.tag, ".d2.load_pc"},  64'(load_pc2),         64'(m_e.lpc2));
            check_val({m_e.tag, ".d2.pc_sel"},   64'(pc_sel_redirect2), 64'(m_e.sel));
            check_val({m_e.tag, ".d2.pc_redir"}, 64'(pc_redirect2),     64'(m_e.pcr));
            check_val({m_e.tag, ".d2.inst_rd"},  64'(inst_read2),       64'(m_e.ird));
            check_val({m_e.tag, ".d2.st_load"},  64'(stage_load2),      64'(m_e.ld2));
            check_val({m_e.tag, ".d2.st_flush"}, 64'(stage_flush2),     64'(m_e.fl2));
            check_val({m_e.tag, ".d2.stall"},    64'(stall_cycles2),    64'(m_e.st2));
            check_val({m_e.tag, ".d2.flush"},    64'(flush_count2),     64'(m_e.fc2));
        end
    end

    // Called with inputs already applied (just after a rising edge). Pushes
    // the expectation for this cycle, then advances the counter model.
    task automatic step(input string tag, input logic e_lpc, input logic e_sel,
                        input logic [31:0] e_pcr, input logic [3:0] e_ld,
                        input logic [3:0] e_fl, input logic e_acc,
                        input logic e2_lpc, input logic [3:0] e2_ld, input logic [3:0] e2_fl);
        exp_t e;
        e.tag  = tag;   e.lpc = e_lpc;  e.sel = e_sel;  e.pcr = e_pcr;
        e.ird  = rst;   e.ld  = e_ld;   e.fl  = e_fl;
        e.st   = 32'(m_st);  e.fc = 32'(m_fc);
        e.lpc2 = e2_lpc; e.ld2 = e2_ld; e.fl2 = e2_fl;
        e.st2  = 3'(m_st2);  e.fc2 = 3'(m_fc2);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!rst) begin
            m_st = 0; m_fc = 0; m_st2 = 0; m_fc2 = 0;
        end else begin
            if (!e_lpc) m_st++;
            if (e_acc) m_fc++;
            if (!e2_lpc && m_st2 < 7) m_st2++;
            if (e_acc && m_fc2 < 7) m_fc2++;
        end
    endtask

    task automatic step1(input string tag, input logic e_lpc, input logic e_sel,
                         input logic [31:0] e_pcr, input logic [3:0] e_ld,
                         input logic [3:0] e_fl, input logic e_acc);
        step(tag, e_lpc, e_sel, e_pcr, e_ld, e_fl, e_acc, e_lpc, e_ld, e_fl);
    endtask

    initial begin
        rst = 1'b0; imem_resp = 1'b1; dmem_read = 1'b0; dmem_write = 1'b0; dmem_resp = 1'b0;
        ex_is_load = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        @(posedge clk);
        #1;

        step1("reset", 0, 0, 32'h0, 4'hF, 4'hF, 0);
        rst = 1'b1;
        step1("idle", 1, 0, 32'h0, 4'hF, 4'h0, 0);

        // Data stall: four cycles frozen, resume on the fifth
        dmem_read = 1'b1;
        for (int i = 0; i < 4; i++) step1("dstall", 0, 0, 32'h0, 4'h0, 4'h0, 0);
        dmem_resp = 1'b1;
        step1("dresume", 1, 0, 32'h0, 4'hF, 4'h0, 0);
        dmem_read = 1'b0; dmem_resp = 1'b0; dmem_write = 1'b1;
        step1("dwstall", 0, 0, 32'h0, 4'h0, 4'h0, 0);
        dmem_write = 1'b0;
        step1("dwresume", 1, 0, 32'h0, 4'hF, 4'h0, 0);

        // lw x5 ; add x6,x5,x1
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        step("lu", 0, 0, 32'h0, 4'b1110, 4'b0010, 0, 0, 4'b1110, 4'b0010);
        ex_is_load = 1'b0;
        step("lu_b2", 1, 0, 32'h0, 4'hF, 4'h0, 0, 0, 4'b1110, 4'b0010);
        step1("lu_done", 1, 0, 32'h0, 4'hF, 4'h0, 0);

        // Hazard through rs2
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
        step("lu_rs2", 0, 0, 32'h0, 4'b1110, 4'b0010, 0, 0, 4'b1110, 4'b0010);
        ex_is_load = 1'b0;
        step("lu_rs2_b2", 1, 0, 32'h0, 4'hF, 4'h0, 0, 0, 4'b1110, 4'b0010);

        // No hazard: x0, unused source, non-load
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        step1("nolu_x0", 1, 0, 32'h0, 4'hF, 4'h0, 0);
        ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b0;
        step1("nolu_unused", 1, 0, 32'h0, 4'hF, 4'h0, 0);
        ex_is_load = 1'b0; id_use_rs1 = 1'b1;
        step1("nolu_alu", 1, 0, 32'h0, 4'hF, 4'h0, 0);
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;

        // Redirect with fetch hit
        redirect = 1'b1; redirect_target = 32'h8000_0040;
        step1("redir", 1, 1, 32'h8000_0040, 4'hF, 4'b0011, 1);
        redirect = 1'b0;
        step1("redir_after", 1, 0, 32'h8000_0040, 4'hF, 4'h0, 0);

        // Plain fetch miss
        imem_resp = 1'b0;
        step1("istall", 0, 0, 32'h8000_0040, 4'hF, 4'b0001, 0);
        imem_resp = 1'b1;
        step1("istall_end", 1, 0, 32'h8000_0040, 4'hF, 4'h0, 0);

        // Miss for 3 cycles, redirect in the first
        imem_resp = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_1000;
        step1("miss_redir", 0, 0, 32'h0000_1000, 4'hF, 4'b0011, 1);
        redirect = 1'b0; redirect_target = 32'hDEAD_0000;
        step1("rwait1", 0, 0, 32'h0000_1000, 4'hF, 4'b0011, 0);
        step1("rwait2", 0, 0, 32'h0000_1000, 4'hF, 4'b0011, 0);
        imem_resp = 1'b1;
        step1("rwait_resp", 1, 1, 32'h0000_1000, 4'hF, 4'b0001, 0);
        step1("rwait_done", 1, 0, 32'hDEAD_0000, 4'hF, 4'h0, 0);

        // Redirect and load-use together: redirect wins, no bubble
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        redirect = 1'b1; redirect_target = 32'h0000_0200;
        step1("redir_lu", 1, 1, 32'h0000_0200, 4'hF, 4'b0011, 1);
        ex_is_load = 1'b0; redirect = 1'b0; id_use_rs1 = 1'b0;
        step1("redir_lu_after", 1, 0, 32'h0000_0200, 4'hF, 4'h0, 0);

        // Data stall while waiting on a latched redirect
        imem_resp = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_4000;
        step1("dr_pre", 0, 0, 32'h0000_4000, 4'hF, 4'b0011, 1);
        redirect = 1'b0; redirect_target = 32'h0000_5000; imem_resp = 1'b1; dmem_read = 1'b1;
        step1("dr_stall1", 0, 0, 32'h0000_4000, 4'h0, 4'h0, 0);
        step1("dr_stall2", 0, 0, 32'h0000_4000, 4'h0, 4'h0, 0);
        dmem_resp = 1'b1;
        step1("dr_resume", 1, 1, 32'h0000_4000, 4'hF, 4'b0001, 0);
        dmem_read = 1'b0; dmem_resp = 1'b0;
        step1("dr_done", 1, 0, 32'h0000_5000, 4'hF, 4'h0, 0);

        // Reset during REDIR_WAIT
        imem_resp = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_3000;
        step1("rst_pre", 0, 0, 32'h0000_3000, 4'hF, 4'b0011, 1);
        redirect = 1'b0;
        step1("rst_wait", 0, 0, 32'h0000_3000, 4'hF, 4'b0011, 0);
        rst = 1'b0;
        step1("rst_mid", 0, 0, 32'h0000_3000, 4'hF, 4'hF, 0);
        rst = 1'b1; imem_resp = 1'b1;
        step1("rst_after", 1, 0, 32'h0000_3000, 4'hF, 4'h0, 0);

        // Long stall to saturate the 3-bit counters of u_dut2
        dmem_read = 1'b1;
        for (int i = 0; i < 10; i++) step1("sat", 0, 0, 32'h0000_3000, 4'h0, 4'h0, 0);
        dmem_resp = 1'b1;
        step1("sat_resume", 1, 0, 32'h0000_3000, 4'hF, 4'h0, 0);
        dmem_read = 1'b0; dmem_resp = 1'b0;
        step1("sat_final", 1, 0, 32'h0000_3000, 4'hF, 4'h0, 0);

        check_val("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
